// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: produces a bouncing active-low press/release waveform.
// Bounce gaps come from a free-running 16-bit Galois LFSR.
module key_bounce_gen #(
    parameter int          N_EDGES    = 50,
    parameter int          GAP_W      = 12,
    parameter int          STABLE_CYC = 2_500_000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic key_out,
    output logic busy,
    output logic pressed,
    output logic done
);
    localparam int                HOLD_W    = $clog2(STABLE_CYC + 1);
    localparam logic [15:0]       SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0]       LFSR_MASK = 16'hB400;
    localparam logic [7:0]        LAST_EDGE = 8'(N_EDGES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(STABLE_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        PRESS_HOLD     = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        RELEASE_HOLD   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_new_s;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        edge_q, edge_d;
    logic              key_q, key_d;
    logic              busy_q, busy_d;
    logic              pressed_q, pressed_d;
    logic              done_q, done_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // A zero gap would never count down to a toggle, so it is clamped to one cycle.
    function automatic logic [GAP_W-1:0] gap_from(input logic [GAP_W-1:0] raw);
        return (raw == '0) ? GAP_ONE : raw;
    endfunction

    assign gap_new_s = gap_from(lfsr_q[GAP_W-1:0]);

    // Next-state and output computation for the press/release sequencer.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_step(lfsr_q);
        gap_d     = gap_q;
        hold_d    = hold_q;
        edge_d    = edge_q;
        key_d     = key_q;
        busy_d    = busy_q;
        pressed_d = pressed_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                key_d     = 1'b1;
                pressed_d = 1'b0;
                if (start) begin
                    state_d = PRESS_BOUNCE;
                    gap_d   = gap_new_s;
                    edge_d  = 8'd0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end

            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (gap_q <= GAP_ONE) begin
                    edge_d = edge_q + 8'd1;
                    if (edge_q >= LAST_EDGE) begin
                        // Final edge of the burst is replaced by the settled level.
                        hold_d = HOLD_LOAD;
                        if (state_q == PRESS_BOUNCE) begin
                            key_d     = 1'b0;
                            pressed_d = 1'b1;
                            state_d   = PRESS_HOLD;
                        end else begin
                            key_d     = 1'b1;
                            pressed_d = 1'b0;
                            state_d   = RELEASE_HOLD;
                        end
                    end else begin
                        key_d = ~key_q;
                        gap_d = gap_new_s;
                    end
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end

            PRESS_HOLD: begin
                key_d     = 1'b0;
                pressed_d = 1'b1;
                if (hold_q <= HOLD_ONE) begin
                    gap_d     = gap_new_s;
                    edge_d    = 8'd0;
                    pressed_d = 1'b0;
                    state_d   = RELEASE_BOUNCE;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            RELEASE_HOLD: begin
                key_d     = 1'b1;
                pressed_d = 1'b0;
                if (hold_q <= HOLD_ONE) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            default: begin
                state_d   = IDLE;
                key_d     = 1'b1;
                busy_d    = 1'b0;
                pressed_d = 1'b0;
            end
        endcase
    end

    // State, LFSR, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            gap_q     <= '0;
            hold_q    <= '0;
            edge_q    <= 8'd0;
            key_q     <= 1'b1;
            busy_q    <= 1'b0;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            gap_q     <= gap_d;
            hold_q    <= hold_d;
            edge_q    <= edge_d;
            key_q     <= key_d;
            busy_q    <= busy_d;
            pressed_q <= pressed_d;
            done_q    <= done_d;
        end
    end

    assign key_out = key_q;
    assign busy    = busy_q;
    assign pressed = pressed_q;
    assign done    = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: per-cycle vector tables built from an event-time reference model,
// plus hand-written reset, zero-gap and mid-sequence reset cases.
module tb_key_bounce_gen;
    localparam int          N_EDGES    = 4;
    localparam int          GAP_W      = 4;
    localparam int          STABLE_CYC = 100;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          MAXV       = 512;

    typedef struct packed {
        logic       start;
        logic [3:0] exp;    // {key_out, busy, pressed, done}
    } vec_t;

    vec_t vecs [MAXV];
    int   nvec;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start   = 1'b0;
    logic start_z = 1'b0;
    logic key_out, busy, pressed, done;
    logic key_z, busy_z, pressed_z, done_z;

    int cyc = 0;
    int n_applied = 0;
    int n_miss = 0;

    int p_t [N_EDGES+1];
    int r_t [N_EDGES+1];
    int t_h1, t_done;

    key_bounce_gen #(.N_EDGES(N_EDGES), .GAP_W(GAP_W), .STABLE_CYC(STABLE_CYC), .SEED(SEED)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .key_out(key_out), .busy(busy), .pressed(pressed), .done(done)
    );

    key_bounce_gen #(.N_EDGES(N_EDGES), .GAP_W(GAP_W), .STABLE_CYC(STABLE_CYC), .SEED(16'hACE0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z),
        .key_out(key_z), .busy(busy_z), .pressed(pressed_z), .done(done_z)
    );

    always #5 clk = ~clk;

    // Index of the next active clock edge since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] x;
        x = SEED;
        for (int i = 0; i < n; i++) x = lfsr_step(x);
        return x;
    endfunction

    function automatic int gap_of(input logic [15:0] x);
        int g;
        g = int'(x[GAP_W-1:0]);
        return (g == 0) ? 1 : g;
    endfunction

    task automatic plan(input int k);
        int t;
        t = k;
        for (int j = 1; j <= N_EDGES; j++) begin
            t = t + gap_of(lfsr_at(t));
            p_t[j] = t;
        end
        t_h1 = t + STABLE_CYC;
        t = t_h1;
        for (int j = 1; j <= N_EDGES; j++) begin
            t = t + gap_of(lfsr_at(t));
            r_t[j] = t;
        end
        t_done = t + STABLE_CYC;
    endtask

    // Expected outputs just after active edge e of a sequence planned by plan().
    function automatic logic [3:0] exp_at(input int e);
        int  j;
        logic key, pr;
        pr = 1'b0;
        j  = 0;
        if (e >= t_done) return (e == t_done) ? 4'b1001 : 4'b1000;
        if (e < p_t[1]) begin
            key = 1'b1;
        end else if (e < p_t[N_EDGES]) begin
            for (int i = 1; i <= N_EDGES; i++) if (p_t[i] <= e) j++;
            key = (j % 2 == 1) ? 1'b0 : 1'b1;
        end else if (e < t_h1) begin
            key = 1'b0;
            pr  = 1'b1;
        end else if (e < r_t[1]) begin
            key = 1'b0;
        end else if (e < r_t[N_EDGES]) begin
            for (int i = 1; i <= N_EDGES; i++) if (r_t[i] <= e) j++;
            key = (j % 2 == 1) ? 1'b1 : 1'b0;
        end else begin
            key = 1'b1;
        end
        return {key, 1'b1, pr, 1'b0};
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_applied++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Builds the vector table for one sequence starting at the next edge and applies it.
    // Extra start pulses land in PRESS_HOLD and on the edge that ends RELEASE_HOLD.
    task automatic run_seq(input bit pokes, input bit abort);
        int k, pcount, dcount;
        logic [3:0] got;
        k = cyc;
        plan(k);
        nvec = abort ? (t_h1 - k + 2) : (t_done - k + 1);
        for (int i = 0; i < nvec; i++) begin
            vecs[i].start = (i == 0) || (pokes && ((k + i == p_t[N_EDGES] + 5) || (k + i == t_done)));
            vecs[i].exp   = exp_at(k + i);
        end
        pcount = 0;
        dcount = 0;
        for (int i = 0; i < nvec; i++) begin
            start = vecs[i].start;
            @(negedge clk);
            got = {key_out, busy, pressed, done};
            if (pressed === 1'b1) pcount++;
            if (done === 1'b1) dcount++;
            n_applied++;
            if (got !== vecs[i].exp) begin
                n_miss++;
                $display("FAIL seq_vec %0d edge %0d: got %b want %b (key,busy,pressed,done)",
                         i, k + i, got, vecs[i].exp);
            end
        end
        start = 1'b0;
        if (!abort) begin
            check("press_hold_len", pcount, STABLE_CYC);
            check("done_count", dcount, 1);
        end
    endtask

    initial begin
        // Reset held with clock running and start asserted.
        repeat (2) @(negedge clk);
        start   = 1'b1;
        start_z = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'({key_out, busy, pressed, done}), int'(4'b1000));
        end
        check("reset_outputs_z", int'({key_z, busy_z, pressed_z, done_z}), int'(4'b1000));
        start   = 1'b0;
        start_z = 1'b0;
        rst_n   = 1'b1;

        // Seed 0xACE0 has a zero low nibble: first gap clamps to one cycle.
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        check("clamp_busy_key", int'({key_z, busy_z}), int'(2'b11));
        check("main_idle", int'({key_out, busy}), int'(2'b10));
        @(negedge clk);
        check("clamp_toggle", int'(key_z), 0);

        // Sequence with ignored start pulses, then a new start one cycle after done.
        run_seq(1'b1, 1'b0);
        run_seq(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("idle_after_seq", int'({key_out, busy, pressed, done}), int'(4'b1000));

        // Reset during RELEASE_BOUNCE clears outputs immediately.
        run_seq(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset", int'({key_out, busy, pressed, done}), int'(4'b1000));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_restart_cyc", cyc, 3);
        run_seq(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/key_bounce_gen.md
# key_bounce_gen

Synthesizable mechanical-key emulator that produces a bouncing, active-low key waveform: a burst of pseudo-random-width glitches, a stable press, another glitch burst, and a stable release. It drives the `key_in` of `key_filter` on-board for hardware self-test of the debouncer, replacing a physical button. It is the source end of the key interface that `key_filter` receives.

## Interface
- `N_EDGES`, 50: number of bounce toggles per bounce burst (press and release); legal range 1..255.
- `GAP_W`, 12: width of the random gap field; each gap is 1..2^GAP_W−1 cycles.
- `STABLE_CYC`, 2_500_000: cycles held stable after each burst (50 ms at 50 MHz).
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero, and a value of 0 is replaced by 16'hACE1.

- `clk` in 1: system clock, 50 MHz nominal.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request for one full press/release sequence.
- `key_out` out 1: emulated key level; 1 = released, 0 = pressed.
- `busy` out 1: high while a sequence is in progress.
- `pressed` out 1: high only during the stable-press hold (PRESS_HOLD).
- `done` out 1: one-cycle pulse when a sequence completes.

## Operation
- Reset values: `key_out`=1, `busy`=0, `pressed`=0, `done`=0, state IDLE, LFSR=SEED, counters 0.
- LFSR: 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1). It shifts right every clock in every state, including IDLE.
- Gap load: `gap = lfsr[GAP_W-1:0]`; if that is 0, `gap = 1`. The gap counter is loaded with `gap` and decrements each cycle.
- States:
  - IDLE: `key_out`=1. `start`=1 moves to PRESS_BOUNCE, loads the first gap, clears the edge count, and sets `busy`.
  - PRESS_BOUNCE: when the gap counter reaches 1, toggle `key_out`, increment the edge count, and reload a new gap. On the N_EDGES-th toggle the block instead forces `key_out`=0, loads the hold counter with STABLE_CYC, and moves to PRESS_HOLD.
  - PRESS_HOLD: `key_out`=0 and `pressed`=1. When the hold counter expires, load a gap, clear the edge count, and move to RELEASE_BOUNCE.
  - RELEASE_BOUNCE: same as PRESS_BOUNCE, but after the final toggle `key_out` is forced to 1 and the block moves to RELEASE_HOLD.
  - RELEASE_HOLD: `key_out`=1. When the hold counter expires, pulse `done`, clear `busy`, and return to IDLE.
- The first bounce toggle always drives `key_out` 1→0. The forced level at the end of a burst may or may not produce an extra edge, depending on N_EDGES parity. Both cases are legal.
- `start` while `busy`=1 is ignored (not queued).
- `start` in the same cycle `done` pulses is ignored, because the state is still RELEASE_HOLD. A new sequence requires `start` at least 1 cycle after `done`.
- Counter widths: the hold counter is sized as clog2(STABLE_CYC+1), the gap counter is GAP_W bits, and the edge count is 8 bits.

## Timing
- All outputs are registered. `start` sampled at edge T gives `busy`=1 at T+1, and the gap loaded at T comes from the LFSR value at T.
- A gap of g cycles means the toggle appears g cycles after the load edge, so consecutive `key_out` edges in a burst are 1..2^GAP_W−1 cycles apart.
- Hold duration is exactly STABLE_CYC cycles from the final burst edge to the next state change.
- `pressed` rises in the same cycle `key_out` is forced 0 and falls when RELEASE_BOUNCE is entered.
- `done` is high for exactly 1 cycle, and `busy` falls in that same cycle.
- Sequence length is deterministic for a given SEED and start cycle: the sum of 2·N_EDGES gaps + 2·STABLE_CYC + 1.
- Reset mid-sequence: all outputs return to reset values asynchronously, and no `done` is issued.

## Test plan
Use N_EDGES=4, GAP_W=4, STABLE_CYC=100, SEED=16'hACE1 unless stated.
- Reset check: hold `rst_n`=0 and toggle `clk` → `key_out`=1, `busy`=0, `pressed`=0, `done`=0. Pulse `start` during reset → no effect.
- Single sequence: one `start` pulse → `busy`=1 on the next cycle. Expect 4 toggles, each 1..15 cycles apart, then `key_out`=0 with `pressed`=1 for exactly 100 cycles. Then 4 toggles, then `key_out`=1 for 100 cycles, then one `done` pulse. Total length must match the bench's LFSR reference model.
- Start while busy: pulse `start` during PRESS_HOLD and again in the `done` cycle → exactly one `done` and no second sequence. Pulse `start` 1 cycle after `done` → a new sequence begins.
- Reset mid-operation: assert `rst_n`=0 during RELEASE_BOUNCE → `key_out`=1 and `busy`=0 immediately. After release, LFSR restarts from SEED, giving an identical gap sequence on the next `start`.
- Zero-gap clamp: choose SEED so `lfsr[3:0]`=0 at load → that gap is 1 cycle and the toggle appears on the next edge.
- Integration: run with N_EDGES=50, GAP_W=12, STABLE_CYC=2_500_000 driving `key_filter` → exactly one `key_flag` pulse with `key_state`=0 on press, and one with `key_state`=1 on release, per sequence. Run 3 sequences back-to-back.
